// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
//
// RV32I instruction-decode / operand-fetch stage that sits directly upstream of
// the register file.  The instruction is decoded combinationally, the register
// file read ports are driven in the same cycle, the immediate is formed and the
// writeback bypass is applied.  The result is then registered into an ID/EX
// pipeline register that has a valid/ready handshake on both sides.
//
// Parameters
//   BYPASS_EN     1: forward the writeback port onto operands, 0: raw RF data
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        fetch-side handshake
//   in_instr, in_pc            instruction word and its PC
//   flush                      squash the ID/EX register (redirect)
//   rf_rs1/rf_rs2 (+_en)       register file read addresses and enables
//   rf_rs1_data/rf_rs2_data    register file read data (0 when not enabled)
//   wb_rd_en, wb_rd, wb_data   writeback port (also feeds the register file)
//   out_valid / out_ready      execute-side handshake
//   out_pc .. out_illegal      registered ID/EX payload
// ----------------------------------------------------------------------------
module decode_stage #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,

    input  logic        flush,

    output logic [4:0]  rf_rs1,
    output logic [4:0]  rf_rs2,
    output logic        rf_rs1_en,
    output logic        rf_rs2_en,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,

    input  logic        wb_rd_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic        out_rd_en,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic        out_illegal
);

    // ------------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------------
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcFence  = 7'b0001111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_sel_e;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [4:0]  rd_field;
    logic        legal;
    logic        rs1_used;
    logic        rs2_used;
    logic        rd_used;
    logic        rd_write;
    imm_sel_e    imm_sel;
    logic [31:0] imm;

    assign opcode   = in_instr[6:0];
    assign rd_field = in_instr[11:7];

    // Every supported opcode ends in 2'b11, so a compressed or otherwise
    // malformed low pair falls into the default arm and is flagged illegal.
    // The default arm also leaves every enable low.
    always_comb begin
        legal    = 1'b1;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        rd_used  = 1'b0;
        imm_sel  = ImmNone;
        case (opcode)
            OpcOp: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                rd_used  = 1'b1;
            end
            OpcOpImm, OpcLoad: begin
                rs1_used = 1'b1;
                rd_used  = 1'b1;
                imm_sel  = ImmI;
            end
            OpcJalr: begin
                rs1_used = 1'b1;
                rd_used  = 1'b1;
                imm_sel  = ImmI;
            end
            OpcStore: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm_sel  = ImmS;
            end
            OpcBranch: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm_sel  = ImmB;
            end
            OpcJal: begin
                rd_used = 1'b1;
                imm_sel = ImmJ;
            end
            OpcLui, OpcAuipc: begin
                rd_used = 1'b1;
                imm_sel = ImmU;
            end
            OpcFence: begin
                imm_sel = ImmNone;
            end
            OpcSystem: begin
                imm_sel = ImmI;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // A write to x0 is architecturally discarded, so never advertise it.
    assign rd_write = rd_used && (rd_field != 5'd0);

    always_comb begin
        imm = 32'd0;
        case (imm_sel)
            ImmI:    imm = {{20{in_instr[31]}}, in_instr[31:20]};
            ImmS:    imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            ImmB:    imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            ImmU:    imm = {in_instr[31:12], 12'd0};
            ImmJ:    imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Register file read ports
    // ------------------------------------------------------------------------
    assign rf_rs1    = in_instr[19:15];
    assign rf_rs2    = in_instr[24:20];
    assign rf_rs1_en = rs1_used;
    assign rf_rs2_en = rs2_used;

    // ------------------------------------------------------------------------
    // Writeback bypass: the register file only shows a write on the cycle
    // after it happens, so a same-cycle writeback to a source is forwarded.
    // ------------------------------------------------------------------------
    logic        fwd_rs1;
    logic        fwd_rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign fwd_rs1 = BYPASS_EN && rf_rs1_en && wb_rd_en &&
                     (wb_rd == rf_rs1) && (rf_rs1 != 5'd0);
    assign fwd_rs2 = BYPASS_EN && rf_rs2_en && wb_rd_en &&
                     (wb_rd == rf_rs2) && (rf_rs2 != 5'd0);

    always_comb begin
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        if (rf_rs1_en) begin
            rs1_val = fwd_rs1 ? wb_data : rf_rs1_data;
        end
        if (rf_rs2_en) begin
            rs2_val = fwd_rs2 ? wb_data : rf_rs2_data;
        end
    end

    // ------------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------------
    logic accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= 32'd0;
            out_rs1_val  <= 32'd0;
            out_rs2_val  <= 32'd0;
            out_imm      <= 32'd0;
            out_rd       <= 5'd0;
            out_rd_en    <= 1'b0;
            out_opcode   <= 7'd0;
            out_funct3   <= 3'd0;
            out_funct7b5 <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            // Payload is left stale; only the valid bit matters downstream.
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_rs1_val  <= rs1_val;
            out_rs2_val  <= rs2_val;
            out_imm      <= imm;
            out_rd       <= rd_field;
            out_rd_en    <= rd_write;
            out_opcode   <= opcode;
            out_funct3   <= in_instr[14:12];
            out_funct7b5 <= in_instr[30];
            out_illegal  <= !legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
